// File: rtl/memload_if.sv
`default_nettype none
// ============================================================================
// Module   : memload_if
// Purpose  : Request, memory-read and response signals of the memload block.
//            The slave modport is the memload view; the master modport is
//            the view of the environment that drives requests, models the
//            memory and consumes responses.
// Revision : 1.0 - initial release
// ============================================================================
interface memload_if;
   // request channel
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   // memory read channel
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   // response channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_error;

   modport slave (
      input  req_valid, req_addr, req_size, req_unsigned,
      output req_ready,
      output mem_rd_en, mem_addr,
      input  mem_rvalid, mem_rdata,
      output rsp_valid, rsp_data, rsp_error,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_addr, req_size, req_unsigned,
      input  req_ready,
      input  mem_rd_en, mem_addr,
      output mem_rvalid, mem_rdata,
      input  rsp_valid, rsp_data, rsp_error,
      output rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/memload.sv
`default_nettype none
// ============================================================================
// Module   : memload
// Purpose  : Single-outstanding load unit. Accepts a byte/halfword/word load,
//            issues one word-aligned memory read, extracts and sign/zero
//            extends the addressed lane, and returns it on a valid/ready
//            response channel. Misaligned or reserved-size requests return
//            an error without touching memory.
//            Optional macro MEMLOAD_TIMEOUT_EN: adds a WAIT-state timeout of
//            TO_CYCLES cycles that answers with an error.
// Revision : 1.0 - initial release
// ============================================================================
module memload #(
   parameter int TO_CYCLES = 64
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   memload_if.slave    bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        init_q;            // low in reset, high from the first edge after release
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic        accept;
   logic        misaligned_req;
   logic        in_flight;
   logic        timeout;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_result;

   assign accept    = bus.req_valid && init_q && (state_q == ST_IDLE);
   assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

   // Alignment check on the incoming request, evaluated on the acceptance cycle
   always_comb begin
      misaligned_req = 1'b0;
      case (bus.req_size)
         2'b00:   misaligned_req = 1'b0;
         2'b01:   misaligned_req = bus.req_addr[0];
         2'b10:   misaligned_req = (bus.req_addr[1:0] != 2'b00);
         default: misaligned_req = 1'b1;
      endcase
   end

   // Lane extraction and extension of the returned memory word
   always_comb begin
      byte_sel = bus.mem_rdata[8*addr_q[1:0] +: 8];
      half_sel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (size_q)
         2'b00:   load_result = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_result = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: load_result = bus.mem_rdata;
      endcase
   end

`ifdef MEMLOAD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   // Cycle counter: cleared when a read is launched, counts ISSUE/WAIT cycles
   always_comb begin
      cnt_inc = cnt_q + 1'b1;
      cnt_d   = cnt_q;
      if (accept && !misaligned_req) begin
         cnt_d = '0;
      end else if (in_flight) begin
         cnt_d = cnt_inc;
      end
      timeout = in_flight && (cnt_inc == CNT_W'(TO_CYCLES));
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
      end
   end

   // Next-state logic; returned data takes priority over a coincident timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = misaligned_req ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (bus.mem_rvalid || timeout) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // Request capture and response result selection
   always_comb begin
      addr_d = addr_q;
      size_d = size_q;
      uns_d  = uns_q;
      data_d = data_q;
      err_d  = err_q;
      if (accept) begin
         addr_d = bus.req_addr;
         size_d = bus.req_size;
         uns_d  = bus.req_unsigned;
         data_d = 32'h0;
         err_d  = misaligned_req;
      end else if (in_flight) begin
         if (bus.mem_rvalid) begin
            data_d = load_result;
            err_d  = 1'b0;
         end else if (timeout) begin
            data_d = 32'h0;
            err_d  = 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= 32'h0;
         size_q <= 2'b00;
         uns_q  <= 1'b0;
         data_q <= 32'h0;
         err_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         size_q <= size_d;
         uns_q  <= uns_d;
         data_q <= data_d;
         err_q  <= err_d;
      end
   end

   // Outputs decoded from the registered state; everything is zero outside its state
   always_comb begin
      bus.req_ready = init_q && (state_q == ST_IDLE);
      bus.mem_rd_en = (state_q == ST_ISSUE);
      bus.mem_addr  = (state_q == ST_ISSUE) ? {addr_q[31:2], 2'b00} : 32'h0;
      bus.rsp_valid = (state_q == ST_RESP);
      bus.rsp_data  = (state_q == ST_RESP) ? data_q : 32'h0;
      bus.rsp_error = (state_q == ST_RESP) ? err_q : 1'b0;
   end

endmodule
`default_nettype wire

// File: doc/memload.md
MEMLOAD -- requirements
Module: memload

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 64: the WAIT-state timeout in cycles, used only when MEMLOAD_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a load request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port req_addr, input, 32 bits: the byte address.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 The block SHALL have port req_unsigned, input, 1 bit: 1 selects zero-extension, 0 selects sign-extension.
REQ-009 The block SHALL have port mem_rd_en, output, 1 bit: one-cycle memory read strobe.
REQ-010 The block SHALL have port mem_addr, output, 32 bits: the word-aligned read address.
REQ-011 The block SHALL have port mem_rvalid, input, 1 bit: mem_rdata is valid.
REQ-012 The block SHALL have port mem_rdata, input, 32 bits: the full memory word; byte lane k is bits [8k+7:8k].
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-015 The block SHALL have port rsp_data, output, 32 bits: the aligned, extended load result.
REQ-016 The block SHALL have port rsp_error, output, 1 bit: misaligned access, reserved size, or timeout.

Function
REQ-017 The block SHALL use four states, IDLE, ISSUE, WAIT and RESP, with one request in flight at most.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1, and addr, size and unsigned are registered on that cycle.
REQ-019 An accepted request SHALL be misaligned when any of these hold: size 01 with addr[0]=1; size 10 with addr[1:0]≠00; size 11.
REQ-020 On acceptance of a misaligned request, the block SHALL go from IDLE to RESP with rsp_error=1 and rsp_data=0, and SHALL NOT assert mem_rd_en.
REQ-021 On acceptance of an aligned request, the block SHALL go from IDLE to ISSUE; in ISSUE, mem_rd_en=1 for exactly one cycle and mem_addr={addr[31:2],2'b00}.
REQ-022 mem_rvalid SHALL be sampled in ISSUE and WAIT; if it is 1, mem_rdata is captured and the state goes to RESP; otherwise ISSUE goes to WAIT, or WAIT holds.
REQ-023 mem_rvalid SHALL be ignored in IDLE and RESP.
REQ-024 Byte extraction SHALL select lane addr[1:0]; halfword extraction SHALL select bits [31:16] when addr[1]=1, else [15:0]; a word is passed unchanged.
REQ-025 Byte and halfword results SHALL be extended to 32 bits: zero-extended when req_unsigned=1, sign-extended from the MSB otherwise; req_unsigned has no effect for words.
REQ-026 In RESP, rsp_valid=1 and rsp_data/rsp_error SHALL be held stable until rsp_ready=1; on that cycle the state returns to IDLE.
REQ-027 A new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-028 Latency SHALL be: with zero-wait memory (mem_rvalid in ISSUE), rsp_valid rises 2 cycles after acceptance; a misaligned error rises 1 cycle after acceptance.
REQ-029 Outside RESP, rsp_data and rsp_error SHALL be 0; mem_addr SHALL be 0 outside ISSUE.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and the outputs SHALL be: req_ready=0, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_error=0.
REQ-031 req_ready SHALL become 1 on the first clock edge after rst_n deasserts.
REQ-032 Reset in any state SHALL abort the operation, discard any pending response, and leave a later stale mem_rvalid ignored.

Configuration
REQ-033 With MEMLOAD_TIMEOUT_EN defined, the block SHALL use a cycle counter that clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
REQ-034 With MEMLOAD_TIMEOUT_EN defined, when the counter reaches TO_CYCLES without mem_rvalid, the block SHALL go to RESP with rsp_error=1 and rsp_data=0.
REQ-035 With MEMLOAD_TIMEOUT_EN defined, if mem_rvalid=1 on the same cycle the timeout is reached, the block SHALL take the data (no error).
REQ-036 Without MEMLOAD_TIMEOUT_EN, the block SHALL have no counter, WAIT SHALL hold indefinitely, and TO_CYCLES SHALL be unused.

Verification
REQ-037 Byte signed load: addr 0x103, size 00, unsigned 0, mem_rdata 0x80FF_1234, zero-wait memory -> mem_addr 0x100, rsp_data 0xFFFF_FF80, rsp_error 0, rsp_valid 2 cycles after acceptance.
REQ-038 Halfword unsigned load: addr 0x202, size 01, unsigned 1, mem_rdata 0x9ABC_5678, 3-cycle memory delay -> rsp_data 0x0000_9ABC.
REQ-039 Misaligned word load: addr 0x301, size 10 -> mem_rd_en never asserts, rsp_error 1, rsp_data 0; the same with size 11.
REQ-040 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready 0 throughout, and a new request is accepted the cycle after the handshake.
REQ-041 Reset mid-WAIT, with mem_rvalid pulsed after reset -> all outputs 0, no rsp_valid, req_ready 1 after the release edge.
REQ-042 With MEMLOAD_TIMEOUT_EN and TO_CYCLES=4, and mem_rvalid never asserted -> rsp_error 1 after 4 ISSUE/WAIT cycles; without the macro, rsp_valid stays 0 for 100 cycles.
